// File: rtl/demux_select_sequencer.sv
// rtl/demux_select_sequencer.sv - handshake-fed select/data sequencer for a 1:4 gate-level demux
//
// Accepts 1-bit words over in_valid/in_ready and drives the demux data input (a) and
// selects {s1,s0}. Each word is held on a for HOLD_CYCLES cycles and followed by one
// idle gap cycle. The channel comes from a round-robin pointer or from chan_sel.
// The round-robin pointer moves only at the end of the gap cycle, so a is low on
// both sides of that select change.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset_n   in   1      synchronous reset, active low
//   rr_mode   in   1      1 = round-robin channel, 0 = fixed channel chan_sel
//   chan_sel  in   2      fixed channel {s1,s0}, sampled at accept
//   in_valid  in   1      upstream word valid
//   in_data   in   1      upstream data bit
//   in_ready  out  1      sequencer can take a word (IDLE and not in reset)
//   a         out  1      demux data input
//   s0, s1    out  1      demux selects
//   busy      out  1      word in flight
//   word_cnt  out  CNT_W  delivered words, modulo 2^CNT_W
//   cnt_wrap  out  1      one-cycle pulse after word_cnt wraps to 0
module demux_select_sequencer #(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rr_mode,
  input  logic [1:0]       chan_sel,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             in_ready,
  output logic             a,
  output logic             s0,
  output logic             s1,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt,
  output logic             cnt_wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic       data_reg;
  logic       rr_reg;
  logic [1:0] ptr;
  logic [7:0] hold_cnt;
  logic       accept;

  assign in_ready = reset_n && (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign s1       = ptr[1];
  assign s0       = ptr[0];
  // data_reg is cleared when leaving DRIVE, so it is a directly and needs no decode.
  assign a        = data_reg;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE:   if (hold_cnt == 8'd0) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      data_reg <= 1'b0;
      rr_reg   <= 1'b0;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
      word_cnt <= '0;
      cnt_wrap <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            data_reg <= in_data;
            hold_cnt <= HOLD_INIT;
            // rr_mode is latched so a mid-frame change cannot alter this word's gap update.
            rr_reg   <= rr_mode;
            if (!rr_mode) ptr <= chan_sel;
          end
        end
        DRIVE: begin
          if (hold_cnt == 8'd0) data_reg <= 1'b0;
          else                  hold_cnt <= hold_cnt - 8'd1;
        end
        GAP: begin
          word_cnt <= word_cnt + 1'b1;
          cnt_wrap <= &word_cnt;
          if (rr_reg) ptr <= ptr + 2'd1;
        end
        default: begin
          data_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_select_sequencer.sv
// tb/tb_demux_select_sequencer.sv - directed bench for demux_select_sequencer
module tb_demux_select_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rr_mode;
  logic [1:0] chan_sel;
  logic       in_valid;
  logic       in_data;
  logic [2:0] in_ready, a, s0, s1, busy, cnt_wrap;
  logic [3:0] word_cnt [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: HOLD_CYCLES=1, instance 1: HOLD_CYCLES=3, instance 2: HOLD_CYCLES=4.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int H = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    demux_select_sequencer #(.HOLD_CYCLES(H), .CNT_W(4)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rr_mode  (rr_mode),
      .chan_sel (chan_sel),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready[k]),
      .a        (a[k]),
      .s0       (s0[k]),
      .s1       (s1[k]),
      .busy     (busy[k]),
      .word_cnt (word_cnt[k]),
      .cnt_wrap (cnt_wrap[k])
    );
  end

  function automatic logic [1:0] sel(input int k);
    return {s1[k], s0[k]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 1'b0;
    rr_mode  = 1'b0;
    chan_sel = 2'd0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 1'b1;
    rr_mode  = 1'b1;
    chan_sel = 2'd3;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({a[k], sel(k), busy[k], cnt_wrap[k], in_ready[k]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got a=%b s=%0d busy=%b wrap=%b rdy=%b exp all 0",
                 k, a[k], sel(k), busy[k], cnt_wrap[k], in_ready[k]);
      end
      checks++;
      if (word_cnt[k] !== 4'd0) begin
        errors++;
        $display("FAIL reset_word_cnt dut%0d got %0d exp 0", k, word_cnt[k]);
      end
    end
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    checks++;
    if (in_ready !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got %b exp 111", in_ready);
    end
  endtask

  task automatic test_round_robin();
    logic       exp_a;
    logic [1:0] exp_s;
    logic [3:0] exp_c;
    apply_reset();
    rr_mode  = 1'b1;
    in_data  = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_a = (i % 3 == 1);
      exp_s = 2'((i / 3) % 4);
      exp_c = 4'(i / 3);
      checks++;
      if (a[0] !== exp_a) begin
        errors++;
        $display("FAIL rr_a cycle %0d got %b exp %b", i, a[0], exp_a);
      end
      checks++;
      if (sel(0) !== exp_s) begin
        errors++;
        $display("FAIL rr_sel cycle %0d got %0d exp %0d", i, sel(0), exp_s);
      end
      checks++;
      if (word_cnt[0] !== exp_c) begin
        errors++;
        $display("FAIL rr_word_cnt cycle %0d got %0d exp %0d", i, word_cnt[0], exp_c);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_fixed_hold3();
    logic exp_a;
    logic exp_r;
    apply_reset();
    rr_mode  = 1'b0;
    chan_sel = 2'd2;
    in_data  = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      exp_a = (j <= 3);
      exp_r = (j == 5);
      checks++;
      if (a[1] !== exp_a) begin
        errors++;
        $display("FAIL fixed_a cycle %0d got %b exp %b", j, a[1], exp_a);
      end
      checks++;
      if (in_ready[1] !== exp_r) begin
        errors++;
        $display("FAIL fixed_ready cycle %0d got %b exp %b", j, in_ready[1], exp_r);
      end
      checks++;
      if (sel(1) !== 2'd2) begin
        errors++;
        $display("FAIL fixed_sel cycle %0d got %0d exp 2", j, sel(1));
      end
      if (j < 5) step();
    end
    checks++;
    if (word_cnt[1] !== 4'd1) begin
      errors++;
      $display("FAIL fixed_word_cnt got %0d exp 1", word_cnt[1]);
    end
  endtask

  task automatic test_select_stability();
    int         changes = 0;
    int         cyc = 0;
    int         accepts = 0;
    logic       exp_a;
    logic       prev_a = 1'b0;
    logic [1:0] prev_s = 2'd0;
    apply_reset();
    rr_mode = 1'b1;
    while (changes < 1000 && cyc < 8000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 1'($urandom_range(0, 1));
      exp_a    = (in_valid && in_ready[0]) ? in_data : 1'b0;
      if (in_valid && in_ready[0]) accepts++;
      step();
      cyc++;
      checks++;
      if (a[0] !== exp_a) begin
        errors++;
        $display("FAIL stab_a cycle %0d got %b exp %b", cyc, a[0], exp_a);
      end
      if (sel(0) !== prev_s) begin
        changes++;
        checks++;
        if (prev_a !== 1'b0 || a[0] !== 1'b0) begin
          errors++;
          $display("FAIL stab_glitch cycle %0d got a_before=%b a_after=%b exp 0 0", cyc, prev_a, a[0]);
        end
      end
      prev_a = a[0];
      prev_s = sel(0);
    end
    in_valid = 1'b0;
    checks++;
    if (changes < 1000) begin
      errors++;
      $display("FAIL stab_timeout got %0d select changes exp 1000", changes);
    end
    step();
    step();
    step();
    checks++;
    if (word_cnt[0] !== 4'(accepts % 16)) begin
      errors++;
      $display("FAIL stab_word_cnt got %0d exp %0d", word_cnt[0], accepts % 16);
    end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    apply_reset();
    rr_mode  = 1'b1;
    in_data  = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (i == 48) in_valid = 1'b0;
      if (cnt_wrap[0]) pulses++;
      checks++;
      if (cnt_wrap[0] !== (i == 48)) begin
        errors++;
        $display("FAIL wrap_pulse cycle %0d got %b exp %b", i, cnt_wrap[0], (i == 48));
      end
      if (i == 45) begin
        checks++;
        if (word_cnt[0] !== 4'd15) begin
          errors++;
          $display("FAIL wrap_pre_cnt got %0d exp 15", word_cnt[0]);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL wrap_pulse_count got %0d exp 1", pulses);
    end
    checks++;
    if (word_cnt[0] !== 4'd0 || sel(0) !== 2'd0) begin
      errors++;
      $display("FAIL wrap_final got cnt=%0d sel=%0d exp cnt=0 sel=0", word_cnt[0], sel(0));
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    rr_mode  = 1'b0;
    chan_sel = 2'd1;
    in_data  = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (a[2] !== 1'b1 || sel(2) !== 2'd1 || busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got a=%b sel=%0d busy=%b exp 1 1 1", a[2], sel(2), busy[2]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready_async got %b exp 0", in_ready[2]);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (a[2] !== 1'b0 || sel(2) !== 2'd0 || busy[2] !== 1'b0 || in_ready[2] !== 1'b0) begin
        errors++;
        $display("FAIL midrst_state cycle %0d got a=%b sel=%0d busy=%b rdy=%b exp 0 0 0 0",
                 i, a[2], sel(2), busy[2], in_ready[2]);
      end
      checks++;
      if (word_cnt[2] !== 4'd0) begin
        errors++;
        $display("FAIL midrst_word_cnt got %0d exp 0", word_cnt[2]);
      end
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_release_ready got %b exp 1", in_ready[2]);
    end
  endtask

  task automatic test_chan_change();
    apply_reset();
    rr_mode  = 1'b0;
    chan_sel = 2'd1;
    in_data  = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chan_sel = 2'd3;
    for (int j = 1; j <= 5; j++) begin
      checks++;
      if (sel(1) !== 2'd1 || a[1] !== (j <= 3)) begin
        errors++;
        $display("FAIL chg_current cycle %0d got sel=%0d a=%b exp sel=1 a=%b", j, sel(1), a[1], (j <= 3));
      end
      if (j < 5) step();
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (sel(1) !== 2'd3 || a[1] !== 1'b1) begin
      errors++;
      $display("FAIL chg_next got sel=%0d a=%b exp sel=3 a=1", sel(1), a[1]);
    end
    repeat (4) step();
    rr_mode  = 1'b1;
    chan_sel = 2'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (sel(1) !== 2'd3) begin
      errors++;
      $display("FAIL chg_rr_resume got sel=%0d exp 3", sel(1));
    end
    repeat (4) step();
    checks++;
    if (sel(1) !== 2'd0 || word_cnt[1] !== 4'd3) begin
      errors++;
      $display("FAIL chg_rr_advance got sel=%0d cnt=%0d exp sel=0 cnt=3", sel(1), word_cnt[1]);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_hold3();
    test_select_stability();
    test_wrap();
    test_reset_mid_frame();
    test_chan_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
